// File: rtl/io881_serial_pkg.sv
// io881_serial_pkg: shared state encoding and frame constants for the io881 serial transmitter
package io881_serial_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam int SERIAL_STOP_BITS  = 1;
  localparam int SERIAL_DATA_BITS  = 8;
  localparam int FRAME_BITS        = 1 + SERIAL_DATA_BITS + SERIAL_STOP_BITS;
  localparam int FRAME_BITS_PARITY = FRAME_BITS + 1;
endpackage

// File: rtl/fifo_serial_baud_gen.sv
// fifo_serial_baud_gen: latches the bit-period divisor at pop and counts each bit down to a bit_end pulse
module fifo_serial_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 bit_end
);
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt;

  assign bit_end = (cnt == '0);

  // Capture divisor on pop; reload the latched value at the end of every bit, else count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= divisor;
      cnt   <= divisor;
    end else begin
      cnt   <= bit_end ? div_q : cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a fall-through FIFO output element into async serial frames (parity via FIFO_SERIAL_TX_PARITY_EN)
module fifo_serial_tx
  import io881_serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_full,
  output logic                  fifo_take,
  input  logic [DIV_WIDTH-1:0]  divisor,
  output logic                  tx,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);

  logic [1:0]            rst_q;
  logic                  rst_s_n;
  state_t                state;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] sh;
  logic [CW-1:0]         bit_cnt;
  logic                  bit_end;
  logic                  last_bit;
  logic                  take;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                  par;
`endif

  assign rst_s_n   = rst_q[1];
  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign fifo_take = take & rst_s_n;
  assign busy      = (state != IDLE);

  // Reset asserts immediately and releases two edges later, synchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  fifo_serial_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .rst_n   (rst_s_n),
    .load    (fifo_take),
    .divisor (divisor),
    .bit_end (bit_end)
  );

  // State register; tx is decoded from it, so reset forces the line high at once
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) state <= IDLE;
    else          state <= state_d;
  end

  // Shift register and bit counter: load on pop, shift and count at the end of each data bit
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (fifo_take) begin
      sh      <= fifo_data;
      bit_cnt <= '0;
    end else if (state == DATA && bit_end) begin
      sh      <= sh >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

`ifdef FIFO_SERIAL_TX_PARITY_EN
  // Even parity of the byte as popped
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n)       par <= 1'b0;
    else if (fifo_take) par <= ^fifo_data;
  end
`endif

  // Next state, line level and pop request
  always_comb begin
    state_d = state;
    tx      = 1'b1;
    take    = 1'b0;
    case (state)
      IDLE: begin
        take    = fifo_full;
        state_d = fifo_full ? START : IDLE;
      end
      START: begin
        tx      = 1'b0;
        state_d = bit_end ? DATA : START;
      end
      DATA: begin
        tx = sh[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
        state_d = (bit_end && last_bit) ? PARITY : DATA;
`else
        state_d = (bit_end && last_bit) ? STOP : DATA;
`endif
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        tx      = par;
        state_d = bit_end ? STOP : PARITY;
      end
`endif
      STOP: begin
        take    = bit_end && fifo_full;
        state_d = bit_end ? (fifo_full ? START : IDLE) : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: directed self-checking bench for fifo_serial_tx
module tb_fifo_serial_tx;
  import io881_serial_pkg::*;

`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NB = FRAME_BITS_PARITY;
`else
  localparam int NB = FRAME_BITS;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_full = 1'b0;
  logic        fifo_take;
  logic [15:0] divisor = 16'd3;
  logic        tx;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fifo_serial_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_data (fifo_data),
    .fifo_full (fifo_full),
    .fifo_take (fifo_take),
    .divisor   (divisor),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic pop(input logic [7:0] b, input logic [15:0] d, input logic [7:0] nxt, input logic keep);
    fifo_data = b;
    divisor   = d;
    fifo_full = 1'b1;
    #1 chk("pop_take", fifo_take, 1);
    step();
    fifo_data = nxt;
    fifo_full = keep;
  endtask

  task automatic frame(input logic [7:0] b, input int d, input int chg, input logic [15:0] nd);
    int k = 0;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j <= d; j++) begin
        if (k == chg) divisor = nd;
        #1 chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, i, j), {tx, busy, fifo_take},
               {fbit(b, i), 1'b1, (i == NB - 1 && j == d) && fifo_full});
        k++;
        step();
      end
    end
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      #1 chk("idle", {tx, busy, fifo_take}, 3'b100);
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    #1 chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_take", fifo_take, 0);
    rst_n = 1'b1;
    repeat (3) step();
    idle_chk(100);

    pop(8'hA5, 16'd3, 8'h3C, 1'b0);
    frame(8'hA5, 3, -1, 16'd0);
    idle_chk(3);

    pop(8'h07, 16'd1, 8'h00, 1'b0);
    frame(8'h07, 1, -1, 16'd0);
    idle_chk(2);

    pop(8'h00, 16'd0, 8'hFF, 1'b1);
    frame(8'h00, 0, -1, 16'd0);
    fifo_full = 1'b0;
    frame(8'hFF, 0, -1, 16'd0);
    idle_chk(2);

    pop(8'h5A, 16'd3, 8'hC3, 1'b0);
    frame(8'h5A, 3, 8, 16'd1);
    idle_chk(2);
    pop(8'hC3, 16'd1, 8'h00, 1'b0);
    frame(8'hC3, 1, -1, 16'd0);
    idle_chk(2);

    pop(8'hE0, 16'd3, 8'h00, 1'b0);
    repeat (21) step();
    #1 chk("midframe_tx_low", tx, 0);
    rst_n = 1'b0;
    #1 chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_take", fifo_take, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    idle_chk(20);

    pop(8'h01, 16'hFFFF, 8'h00, 1'b0);
    divisor = 16'd3;
    repeat (65535) step();
    #1 chk("maxdiv_start_last", tx, 0);
    step();
    #1 chk("maxdiv_data0", tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
